// File: rtl/seven_seg_pkg.sv
// Shared segment type and glyph constants for the seven-segment scan driver.
// Bit order is {a,b,c,d,e,f,g} with seg[6] = a; a 1 lights the segment.
package seven_seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0    = 7'h7E;
    localparam seg_t SEG_1    = 7'h30;
    localparam seg_t SEG_2    = 7'h6D;
    localparam seg_t SEG_3    = 7'h79;
    localparam seg_t SEG_4    = 7'h33;
    localparam seg_t SEG_5    = 7'h5B;
    localparam seg_t SEG_6    = 7'h5F;
    localparam seg_t SEG_7    = 7'h70;
    localparam seg_t SEG_8    = 7'h7F;
    localparam seg_t SEG_9    = 7'h7B;
    localparam seg_t SEG_A    = 7'h77;
    localparam seg_t SEG_B    = 7'h1F;
    localparam seg_t SEG_C    = 7'h4E;
    localparam seg_t SEG_D    = 7'h3D;
    localparam seg_t SEG_E    = 7'h4F;
    localparam seg_t SEG_F    = 7'h47;
    localparam seg_t SEG_DASH = 7'h01;
    localparam seg_t SEG_OFF  = 7'h00;

endpackage

// File: rtl/seven_seg_encoder.sv
// Combinational nibble-to-glyph encoder.
// In BCD mode, nibbles above 9 show a dash; a blanked digit shows nothing.
module seven_seg_encoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       hex_mode_i,
    input  logic       blank_i,
    output seg_t       seg_o
);

    // Blanking wins over everything; otherwise pick the glyph, dashing A-F in BCD mode.
    always_comb begin
        seg_o = SEG_OFF;
        if (!blank_i) begin
            case (nibble_i)
                4'h0:    seg_o = SEG_0;
                4'h1:    seg_o = SEG_1;
                4'h2:    seg_o = SEG_2;
                4'h3:    seg_o = SEG_3;
                4'h4:    seg_o = SEG_4;
                4'h5:    seg_o = SEG_5;
                4'h6:    seg_o = SEG_6;
                4'h7:    seg_o = SEG_7;
                4'h8:    seg_o = SEG_8;
                4'h9:    seg_o = SEG_9;
                4'hA:    seg_o = hex_mode_i ? SEG_A : SEG_DASH;
                4'hB:    seg_o = hex_mode_i ? SEG_B : SEG_DASH;
                4'hC:    seg_o = hex_mode_i ? SEG_C : SEG_DASH;
                4'hD:    seg_o = hex_mode_i ? SEG_D : SEG_DASH;
                4'hE:    seg_o = hex_mode_i ? SEG_E : SEG_DASH;
                default: seg_o = hex_mode_i ? SEG_F : SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/seven_segment_scan_driver.sv
// Time-multiplexed multi-digit seven-segment driver.
// A new value is accepted through valid/ready into a pending register and only
// moves to the displayed shadow register at a frame boundary, so a frame never
// mixes old and new digits. Each slot ends with a one-cycle dark gap against ghosting.
module seven_segment_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 1000,
    parameter bit ACTIVE_LOW_SEG = 1'b0,
    parameter bit ACTIVE_LOW_AN  = 1'b0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    load_valid_i,
    output logic                    load_ready_o,
    input  logic [4*NUM_DIGITS-1:0] load_value_i,
    input  logic                    hex_mode_i,
    input  logic                    blank_lz_i,
    output logic [6:0]              seg_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic                    frame_done_o
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
    logic                    pendingFull_q, pendingFull_d;
    seg_t                    seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frameDone_q, frameDone_d;

    logic                    tick;
    logic                    boundary;
    logic                    accept;
    logic [3:0]              curNibble;
    logic                    curBlank;
    logic [NUM_DIGITS-1:0]   lzMask;
    logic                    aboveZero;
    seg_t                    encSeg;

    assign tick     = (cnt_q == CNT_LAST);
    assign boundary = tick && (idx_q == IDX_LAST);
    assign accept   = load_valid_i && !pendingFull_q;

    // Prescaler and digit index: advance the scanned digit once per refresh slot.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        idx_d = idx_q;
        if (tick) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
    end

    // Handshake and commit: hold one offered value, publish it only at the frame boundary.
    always_comb begin
        shadow_d      = shadow_q;
        pending_d     = pending_q;
        pendingFull_d = pendingFull_q;
        frameDone_d   = boundary;
        if (boundary) begin
            if (accept) begin
                shadow_d = load_value_i;
            end else if (pendingFull_q) begin
                shadow_d = pending_q;
            end
            pendingFull_d = 1'b0;
        end else if (accept) begin
            pending_d     = load_value_i;
            pendingFull_d = 1'b1;
        end
    end

    // Leading-zero mask from the top down, then select the nibble of the digit being scanned.
    always_comb begin
        aboveZero = 1'b1;
        lzMask    = '0;
        curNibble = '0;
        curBlank  = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            aboveZero = aboveZero && (shadow_q[4*i +: 4] == 4'h0);
            lzMask[i] = aboveZero;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                curNibble = shadow_q[4*i +: 4];
                curBlank  = blank_lz_i && lzMask[i];
            end
        end
    end

    seven_seg_encoder u_encoder (
        .nibble_i   (curNibble),
        .hex_mode_i (hex_mode_i),
        .blank_i    (curBlank),
        .seg_o      (encSeg)
    );

    // Output stage: dark on the slot-change edge, otherwise light the current digit.
    always_comb begin
        an_d  = '0;
        seg_d = SEG_OFF;
        if (!tick) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                an_d[i] = (idx_q == IW'(i));
            end
            seg_d = encSeg;
        end
    end

    // State and output registers with synchronous reset; reset drops any pending value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            shadow_q      <= '0;
            pending_q     <= '0;
            pendingFull_q <= 1'b0;
            seg_q         <= SEG_OFF;
            an_q          <= '0;
            frameDone_q   <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shadow_q      <= shadow_d;
            pending_q     <= pending_d;
            pendingFull_q <= pendingFull_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
            frameDone_q   <= frameDone_d;
        end
    end

    assign load_ready_o = !pendingFull_q;
    assign frame_done_o = frameDone_q;
    assign seg_o        = ACTIVE_LOW_SEG ? ~seg_q : seg_q;
    assign an_o         = ACTIVE_LOW_AN  ? ~an_q  : an_q;

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Self-checking bench for seven_segment_scan_driver (4 digits, 4 clocks per slot).
// Expected per-cycle outputs are queued when a load is driven and compared as the
// DUT reaches each cycle; cycle numbers count edges since reset was released.
module tb_seven_segment_scan_driver;

    localparam int ND    = 4;
    localparam int RD    = 4;
    localparam int FRAME = ND * RD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        loadValid = 1'b0;
    logic        hexMode = 1'b0;
    logic        blankLz = 1'b0;
    logic [15:0] loadValue = '0;
    logic        loadReady;
    logic        frameDone;
    logic [6:0]  seg;
    logic [3:0]  an;

    seven_segment_scan_driver #(
        .NUM_DIGITS     (ND),
        .REFRESH_DIV    (RD),
        .ACTIVE_LOW_SEG (1'b0),
        .ACTIVE_LOW_AN  (1'b0)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .load_valid_i (loadValid),
        .load_ready_o (loadReady),
        .load_value_i (loadValue),
        .hex_mode_i   (hexMode),
        .blank_lz_i   (blankLz),
        .seg_o        (seg),
        .an_o         (an),
        .frame_done_o (frameDone)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        bit         chkDisp;
        logic [3:0] an;
        logic [6:0] seg;
        logic       ready;
        logic       fd;
    } exp_t;

    typedef struct {
        logic [15:0]     value;
        logic            hex;
        logic            blz;
        logic [3:0][6:0] segs;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[9];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, req);
        end
    endtask

    task automatic checkOutput();
        exp_t r;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            r = sb.pop_front();
            check1("load_ready", 32'(loadReady), 32'(r.ready));
            check1("frame_done", 32'(frameDone), 32'(r.fd));
            if (r.chkDisp) begin
                check1("an", 32'(an), 32'(r.an));
                check1("seg", 32'(seg), 32'(r.seg));
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) cyc = 0;
        else cyc++;
        #1;
        checkOutput();
    endtask

    task automatic waitPhase(input int phase);
        int n;
        n = 0;
        while ((cyc % FRAME) != phase || loadReady !== 1'b1) begin
            step();
            n++;
            if (n > 100) begin
                check1("wait_ready_timeout", 32'(loadReady), 32'd1);
                return;
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 100) begin
            step();
            n++;
        end
        if (sb.size() > 0) begin
            check1("scoreboard_drain", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    // Queue the full frame that follows boundary edge b, showing the given digits.
    task automatic pushFrame(input int b, input logic [3:0][6:0] segs);
        exp_t r;
        for (int k = 1; k <= FRAME; k++) begin
            r.cyc     = b + k;
            r.chkDisp = 1'b1;
            r.an      = (((k - 1) % RD) == RD - 1) ? 4'b0000 : 4'(1 << ((k - 1) / RD));
            r.seg     = (((k - 1) % RD) == RD - 1) ? 7'h00 : segs[(k - 1) / RD];
            r.ready   = 1'b1;
            r.fd      = ((b + k) % FRAME) == 0;
            sb.push_back(r);
        end
    endtask

    // Offer one value (mid-frame or on the boundary edge), optionally spamming a
    // second value while not ready, and check handshake plus the following frame.
    task automatic applyStimulus(input vec_t v, input bit atBoundary, input bit spam);
        exp_t r;
        int   a;
        int   b;
        hexMode = v.hex;
        blankLz = v.blz;
        waitPhase(atBoundary ? FRAME - 1 : 5);
        a = cyc + 1;
        b = ((a + FRAME - 1) / FRAME) * FRAME;
        for (int e = a; e <= b; e++) begin
            r.cyc     = e;
            r.chkDisp = 1'b0;
            r.an      = '0;
            r.seg     = '0;
            r.ready   = (e == b);
            r.fd      = (e % FRAME) == 0;
            sb.push_back(r);
        end
        pushFrame(b, v.segs);
        loadValid = 1'b1;
        loadValue = v.value;
        step();
        if (spam) begin
            loadValue = ~v.value;
            while (cyc < b) step();
        end
        loadValid = 1'b0;
        drain();
    endtask

    // Hard stop in case something wedges the simulation.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "[TB] timeout");
    end

    // Main test sequence.
    initial begin
        vecs[0] = '{16'h1234, 1'b0, 1'b0, {7'h30, 7'h6D, 7'h79, 7'h33}};
        vecs[1] = '{16'hBEEF, 1'b1, 1'b0, {7'h1F, 7'h4F, 7'h4F, 7'h47}};
        vecs[2] = '{16'hBEEF, 1'b0, 1'b0, {7'h01, 7'h01, 7'h01, 7'h01}};
        vecs[3] = '{16'h0042, 1'b0, 1'b1, {7'h00, 7'h00, 7'h33, 7'h6D}};
        vecs[4] = '{16'h0000, 1'b0, 1'b1, {7'h00, 7'h00, 7'h00, 7'h7E}};
        vecs[5] = '{16'hA5C9, 1'b1, 1'b0, {7'h77, 7'h5B, 7'h4E, 7'h7B}};
        vecs[6] = '{16'h0705, 1'b0, 1'b1, {7'h00, 7'h70, 7'h7E, 7'h5B}};
        vecs[7] = '{16'hD008, 1'b1, 1'b1, {7'h3D, 7'h7E, 7'h7E, 7'h7F}};
        vecs[8] = '{16'h6789, 1'b0, 1'b0, {7'h5F, 7'h70, 7'h7F, 7'h7B}};

        rst = 1'b1;
        step();
        step();
        check1("reset_seg", 32'(seg), 32'h00);
        check1("reset_an", 32'(an), 32'h0);
        check1("reset_ready", 32'(loadReady), 32'd1);
        check1("reset_fd", 32'(frameDone), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i], 1'b0, 1'b0);
        end

        // Offers while busy must be dropped; the first value is what gets shown.
        applyStimulus(vecs[0], 1'b0, 1'b1);

        // Load on the boundary edge itself goes straight to the next frame.
        applyStimulus('{16'h5678, 1'b0, 1'b0, {7'h5B, 7'h5F, 7'h70, 7'h7F}}, 1'b1, 1'b0);

        // Reset mid-frame with a value pending: pending is lost, shadow returns to zero.
        hexMode = 1'b0;
        blankLz = 1'b0;
        waitPhase(5);
        loadValid = 1'b1;
        loadValue = 16'h9999;
        step();
        loadValid = 1'b0;
        check1("pending_ready", 32'(loadReady), 32'd0);
        step();
        step();
        rst = 1'b1;
        step();
        check1("midreset_seg", 32'(seg), 32'h00);
        check1("midreset_an", 32'(an), 32'h0);
        check1("midreset_ready", 32'(loadReady), 32'd1);
        check1("midreset_fd", 32'(frameDone), 32'd0);
        rst = 1'b0;
        begin
            exp_t r;
            for (int e = 1; e <= FRAME; e++) begin
                r.cyc     = e;
                r.chkDisp = 1'b0;
                r.an      = '0;
                r.seg     = '0;
                r.ready   = 1'b1;
                r.fd      = (e == FRAME);
                sb.push_back(r);
            end
        end
        pushFrame(FRAME, {7'h7E, 7'h7E, 7'h7E, 7'h7E});
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
